fetch_unit: RTL and testbench

//  Instruction fetch stage feeding the decoder. Owns the program counter and

---
 rtl/fetch_unit_if.sv | 40 ++++
 rtl/fetch_unit.sv | 113 +++++++++++
 tb/tb_fetch_unit.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: run control, imem req/ack, decoder valid/ready,
// branch redirect and status outputs.
interface fetch_unit_if #(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned INSTR_W = 16
);
  logic               run;
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    instr_pc;
  logic               instr_ready;
  logic               br_taken;
  logic [PC_W-1:0]    br_target;
  logic [PC_W-1:0]    pc;
  logic [7:0]         fetch_count;

  modport master (
    input  run,
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output instr_valid, instr, instr_pc,
    input  instr_ready,
    input  br_taken, br_target,
    output pc, fetch_count
  );

  modport slave (
    output run,
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  instr_valid, instr, instr_pc,
    output instr_ready,
    output br_taken, br_target,
    input  pc, fetch_count
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads imem under req/ack, hands each
// instruction to decode under valid/ready, redirects on taken branches.
module fetch_unit #(
  parameter int unsigned       PC_W     = 8,
  parameter int unsigned       INSTR_W  = 16,
  parameter logic [PC_W-1:0]   RESET_PC = '0
) (
  input logic         clk,
  input logic         reset,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } state_t;

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  state_t             state, state_nxt;
  logic [PC_W-1:0]    pc_q, pc_nxt;
  logic [PC_W-1:0]    addr_q, addr_nxt;
  logic [PC_W-1:0]    instr_pc_q, instr_pc_nxt;
  logic [INSTR_W-1:0] instr_q, instr_nxt;
  logic               valid_q, valid_nxt;
  logic [7:0]         cnt_q, cnt_nxt;
  state_t             resume;

  // Where a completed or abandoned transaction goes next.
  assign resume = bus.run ? REQ : IDLE;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pc_q       <= RESET_PC;
      addr_q     <= '0;
      instr_pc_q <= '0;
      instr_q    <= '0;
      valid_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state      <= state_nxt;
      pc_q       <= pc_nxt;
      addr_q     <= addr_nxt;
      instr_pc_q <= instr_pc_nxt;
      instr_q    <= instr_nxt;
      valid_q    <= valid_nxt;
      cnt_q      <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc_q;
    addr_nxt     = addr_q;
    instr_pc_nxt = instr_pc_q;
    instr_nxt    = instr_q;
    valid_nxt    = valid_q;
    cnt_nxt      = cnt_q;

    case (state)
      IDLE: begin
        if (bus.br_taken) pc_nxt = bus.br_target;
        state_nxt = resume;
      end

      REQ: begin
        // Remember the in-flight address so a redirect can keep it on the bus.
        addr_nxt = pc_q;
        if (bus.br_taken) begin
          pc_nxt    = bus.br_target;
          state_nxt = bus.imem_ack ? resume : DISCARD;
        end else if (bus.imem_ack) begin
          instr_nxt    = bus.imem_rdata;
          instr_pc_nxt = pc_q;
          valid_nxt    = 1'b1;
          pc_nxt       = pc_q + PC_ONE;
          state_nxt    = HOLD;
        end
      end

      HOLD: begin
        if (bus.br_taken) begin
          valid_nxt = 1'b0;
          pc_nxt    = bus.br_target;
          state_nxt = resume;
        end else if (bus.instr_ready) begin
          valid_nxt = 1'b0;
          cnt_nxt   = cnt_q + 8'd1;
          state_nxt = resume;
        end
      end

      DISCARD: begin
        if (bus.br_taken) pc_nxt = bus.br_target;
        if (bus.imem_ack) state_nxt = resume;
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign bus.imem_req    = (state == REQ) || (state == DISCARD);
  assign bus.imem_addr   = (state == DISCARD) ? addr_q : pc_q;
  assign bus.instr_valid = valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.pc          = pc_q;
  assign bus.fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: memory responder, directed scenarios and a
// randomized phase checked against a program-order reference model.
module tb_fetch_unit;

  logic clk;
  logic reset;

  fetch_unit_if #(.PC_W(8), .INSTR_W(16)) bus ();

  fetch_unit #(.PC_W(8), .INSTR_W(16), .RESET_PC(8'h00)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [15:0] mem_word(input logic [7:0] a);
    mem_word = {8'h00, a} ^ 16'hA500;
  endfunction

  // ---------------- memory responder ----------------
  int unsigned mem_wait = 0;
  bit          mem_rand = 1'b0;

  initial begin
    int unsigned wcnt, wcur;
    bit          waiting;
    logic [7:0]  held_addr;
    wcnt = 0; wcur = 0; waiting = 1'b0; held_addr = '0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        bus.imem_ack = 1'b0;
        waiting      = 1'b0;
      end else if (bus.imem_req) begin
        if (waiting) check("imem_addr_stable", 32'(bus.imem_addr), 32'(held_addr));
        if (!waiting) begin
          wcur = mem_rand ? $urandom_range(3, 0) : mem_wait;
          wcnt = 0;
        end
        if (wcnt >= wcur) begin
          bus.imem_ack   = 1'b1;
          bus.imem_rdata = mem_word(bus.imem_addr);
          waiting        = 1'b0;
        end else begin
          bus.imem_ack   = 1'b0;
          bus.imem_rdata = 16'($urandom);
          held_addr      = bus.imem_addr;
          waiting        = 1'b1;
          wcnt++;
        end
      end else begin
        bus.imem_ack = 1'b0;
        waiting      = 1'b0;
      end
    end
  end

  // ---------------- reference model + scoreboard ----------------
  // Program order: after reset or a branch the stream restarts at the target
  // and advances by one per correct-path read; wrong-path reads are dropped.
  typedef struct {
    logic [7:0]  pc;
    logic [15:0] ins;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] exp_fetch = 8'h00;
  logic [7:0] model_cnt = 8'h00;
  bit         wrong_path = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      exp_q.delete();
      exp_fetch  = 8'h00;
      model_cnt  = 8'h00;
      wrong_path = 1'b0;
    end else begin
      if (bus.instr_valid && bus.instr_ready && !bus.br_taken) begin
        if (exp_q.size() == 0) begin
          check("spurious_instr", 32'(bus.instr_pc), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("instr", 32'(bus.instr), 32'(e.ins));
          check("instr_pc", 32'(bus.instr_pc), 32'(e.pc));
          check("fetch_count", 32'(bus.fetch_count), 32'(model_cnt));
        end
        model_cnt = model_cnt + 8'd1;
      end
      if (bus.imem_req && bus.imem_ack) begin
        if (wrong_path || bus.br_taken) begin
          wrong_path = 1'b0;
        end else begin
          check("fetch_addr", 32'(bus.imem_addr), 32'(exp_fetch));
          exp_q.push_back('{pc: exp_fetch, ins: mem_word(exp_fetch)});
          exp_fetch = exp_fetch + 8'd1;
        end
      end else if (bus.imem_req && bus.br_taken) begin
        wrong_path = 1'b1;
      end
      if (bus.br_taken) begin
        exp_q.delete();
        exp_fetch = bus.br_target;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int unsigned budget);
    int unsigned n;
    n = 0;
    while (!bus.instr_valid && n < budget) begin
      tick(1);
      n++;
    end
    check("wait_valid_timeout", 32'(bus.instr_valid), 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_imem_req"},    32'(bus.imem_req),    32'd0);
    check({tag, "_pc"},          32'(bus.pc),          32'h00);
    check({tag, "_instr_valid"}, 32'(bus.instr_valid), 32'd0);
    check({tag, "_instr"},       32'(bus.instr),       32'h0);
    check({tag, "_instr_pc"},    32'(bus.instr_pc),    32'h0);
    check({tag, "_fetch_count"}, 32'(bus.fetch_count), 32'd0);
  endtask

  initial begin
    reset           = 1'b1;
    bus.run         = 1'b0;
    bus.instr_ready = 1'b0;
    bus.br_taken    = 1'b0;
    bus.br_target   = '0;

    // Reset held two cycles, then idle with run low.
    tick(2);
    check_reset_state("reset");
    reset = 1'b0;
    tick(3);
    check("idle_no_req", 32'(bus.imem_req), 32'd0);
    check("idle_pc", 32'(bus.pc), 32'h00);

    // Zero-wait streaming: three deliveries within six cycles of the first req.
    mem_wait = 0;
    bus.instr_ready = 1'b1;
    bus.run = 1'b1;
    tick(7);
    check("stream_fetch_count", 32'(bus.fetch_count), 32'd3);
    bus.run = 1'b0;
    tick(3);

    // Three wait cycles on the read, then decoder stalls four cycles.
    mem_wait = 3;
    bus.instr_ready = 1'b0;
    bus.run = 1'b1;
    tick(1);
    for (int i = 0; i < 3; i++) begin
      check("wait_req", 32'(bus.imem_req), 32'd1);
      check("wait_addr", 32'(bus.imem_addr), 32'h04);
      tick(1);
    end
    tick(1);
    for (int i = 0; i < 4; i++) begin
      check("hold_valid", 32'(bus.instr_valid), 32'd1);
      check("hold_instr", 32'(bus.instr), 32'hA504);
      check("hold_instr_pc", 32'(bus.instr_pc), 32'h04);
      check("hold_no_req", 32'(bus.imem_req), 32'd0);
      tick(1);
    end
    bus.run = 1'b0;
    bus.instr_ready = 1'b1;
    tick(1);
    check("after_hold_valid", 32'(bus.instr_valid), 32'd0);

    // Branch in HOLD with ready high drops the held instruction.
    mem_wait = 0;
    bus.instr_ready = 1'b0;
    bus.run = 1'b1;
    wait_valid(20);
    bus.br_taken = 1'b1;
    bus.br_target = 8'h40;
    bus.instr_ready = 1'b1;
    tick(1);
    bus.br_taken = 1'b0;
    check("br_hold_valid", 32'(bus.instr_valid), 32'd0);
    check("br_hold_count", 32'(bus.fetch_count), 32'd5);
    check("br_hold_req", 32'(bus.imem_req), 32'd1);
    check("br_hold_addr", 32'(bus.imem_addr), 32'h40);
    bus.run = 1'b0;
    tick(4);

    // Branch in REQ before the ack: stale read completes, then refetch 0x10.
    mem_wait = 2;
    bus.run = 1'b1;
    tick(1);
    check("req_addr", 32'(bus.imem_addr), 32'h41);
    bus.br_taken = 1'b1;
    bus.br_target = 8'h10;
    tick(1);
    bus.br_taken = 1'b0;
    check("discard_req", 32'(bus.imem_req), 32'd1);
    check("discard_addr", 32'(bus.imem_addr), 32'h41);
    check("discard_pc", 32'(bus.pc), 32'h10);
    check("discard_valid", 32'(bus.instr_valid), 32'd0);
    tick(1);
    check("discard_valid2", 32'(bus.instr_valid), 32'd0);
    tick(1);
    check("redirect_req", 32'(bus.imem_req), 32'd1);
    check("redirect_addr", 32'(bus.imem_addr), 32'h10);
    check("redirect_valid", 32'(bus.instr_valid), 32'd0);
    tick(3);
    bus.run = 1'b0;
    tick(8);

    // PC wrap from 0xFF.
    mem_wait = 0;
    bus.instr_ready = 1'b1;
    bus.run = 1'b1;
    bus.br_taken = 1'b1;
    bus.br_target = 8'hFF;
    tick(1);
    bus.br_taken = 1'b0;
    check("wrap_addr", 32'(bus.imem_addr), 32'hFF);
    tick(1);
    check("wrap_pc", 32'(bus.pc), 32'h00);
    check("wrap_instr_pc", 32'(bus.instr_pc), 32'hFF);
    check("wrap_instr", 32'(bus.instr), 32'hA5FF);
    bus.run = 1'b0;
    tick(6);

    // Reset while a wrong-path read is outstanding, then while holding.
    mem_wait = 5;
    bus.run = 1'b1;
    tick(1);
    bus.br_taken = 1'b1;
    bus.br_target = 8'h22;
    tick(1);
    bus.br_taken = 1'b0;
    check("pre_reset_discard_req", 32'(bus.imem_req), 32'd1);
    reset = 1'b1;
    tick(1);
    check_reset_state("rst_discard");
    mem_wait = 0;
    bus.instr_ready = 1'b0;
    reset = 1'b0;
    wait_valid(20);
    reset = 1'b1;
    tick(1);
    check_reset_state("rst_hold");
    tick(1);
    reset = 1'b0;

    // Randomized traffic.
    mem_rand = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      bus.run         = ($urandom_range(9, 0) != 0);
      bus.instr_ready = ($urandom_range(2, 0) != 0);
      bus.br_taken    = ($urandom_range(19, 0) == 0);
      bus.br_target   = 8'($urandom);
      tick(1);
    end
    bus.br_taken    = 1'b0;
    bus.run         = 1'b0;
    bus.instr_ready = 1'b1;
    tick(12);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    check("drain_idle", 32'(bus.imem_req), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
